// File: rtl/pq_pkg.sv
// Shared pq types and defaults: queue geometry, op codes, and arbiter FSM states.
// Pure definitions with no latency or backpressure of its own.
package pq_pkg;

  localparam int QUEUE_DEPTH    = 8;
  localparam int DATA_WIDTH     = 16;
  localparam int PQ_ARB_NUM_REQ = 4;

  typedef enum logic [1:0] {
    PUSH = 2'd0,
    POP  = 2'd1,
    DROP = 2'd2,
    RSVD = 2'd3
  } pq_op_e;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } pq_arb_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: the first request at or after ptr wins, combinationally in the same cycle.
// When upd_en is high and there is a winner, ptr moves to winner+1; it never stalls the requesters.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               upd_en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] j;
  logic             found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = IDX_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (upd_en && found) begin
      ptr <= (int'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/pq_req_arbiter.sv
// Shares a single pq between NUM_REQ requesters. The ops are PUSH, POP and DROP. Drop-owner checks are enabled by PQ_ARB_OWNER_CHECK_EN.
// A grant at T gives a response at T+2 at the earliest, and T+1 for an error. The pq strobe is held while its rdy is low.
module pq_req_arbiter
  import pq_pkg::*;
#(
  parameter int NUM_REQ = PQ_ARB_NUM_REQ,
  parameter int DEPTH   = QUEUE_DEPTH,
  parameter int DW      = DATA_WIDTH,
  localparam int ID_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NUM_REQ-1:0]                req_i,
  input  logic [NUM_REQ-1:0][1:0]           op_i,
  input  logic [NUM_REQ-1:0][DW-1:0]        req_data_i,
  input  logic [NUM_REQ-1:0][ID_WIDTH-1:0]  req_id_i,
  output logic [NUM_REQ-1:0]                gnt_o,
  output logic [NUM_REQ-1:0]                rsp_vld_o,
  output logic                              rsp_err_o,
  output logic [DW-1:0]                     rsp_data_o,
  output logic [ID_WIDTH-1:0]               rsp_id_o,
  output logic                              pq_push_o,
  output logic                              pq_pop_o,
  output logic                              pq_drop_o,
  output logic [ID_WIDTH-1:0]               pq_drop_id_o,
  output logic [DW-1:0]                     pq_data_o,
  input  logic [ID_WIDTH-1:0]               pq_push_id_i,
  input  logic                              pq_push_rdy_i,
  input  logic                              pq_pop_rdy_i,
  input  logic                              pq_drop_rdy_i,
  input  logic                              pq_full_i,
  input  logic                              pq_empty_i,
  input  logic [DW-1:0]                     pq_data_i
);

  localparam int IDX_W = idx_width(NUM_REQ);

  pq_arb_state_e        state;
  logic [NUM_REQ-1:0]   arb_req;
  logic [NUM_REQ-1:0]   arb_gnt;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_en;
  pq_op_e               win_op;
  logic                 pre_err;
  logic                 owner_err;
  logic                 accept;

  logic [NUM_REQ-1:0]   gnt_q;
  logic [DW-1:0]        data_q;
  logic [ID_WIDTH-1:0]  id_q;
  logic                 push_q, pop_q, drop_q;
  logic [NUM_REQ-1:0]   rsp_vld_q;
  logic                 rsp_err_q;
  logic [DW-1:0]        rsp_data_q;
  logic [ID_WIDTH-1:0]  rsp_id_q;

  // Requests are masked outside ARB and during reset, so a grant can only pulse in ARB.
  assign arb_en  = rst_ni && (state == ARB);
  assign arb_req = arb_en ? req_i : '0;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk    (clk_i),
    .rst_n  (rst_ni),
    .req    (arb_req),
    .upd_en (arb_en),
    .gnt    (arb_gnt),
    .idx    (arb_idx)
  );

  assign win_op = pq_op_e'(op_i[arb_idx]);
  assign accept = (push_q && pq_push_rdy_i) || (pop_q && pq_pop_rdy_i) ||
                  (drop_q && pq_drop_rdy_i);

`ifdef PQ_ARB_OWNER_CHECK_EN
  localparam int OWN_N = 2 ** ID_WIDTH;

  logic [OWN_N-1:0][IDX_W-1:0] owner_q;
  logic [OWN_N-1:0]            owner_vld_q;
  logic [IDX_W-1:0]            idx_q;
  logic [ID_WIDTH-1:0]         win_id;

  assign win_id    = req_id_i[arb_idx];
  assign owner_err = (win_op == DROP) &&
                     (!owner_vld_q[win_id] || (owner_q[win_id] != arb_idx));

  // pq does not report which ID a POP removed, so owner entries are released only by DROP.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner_q     <= '0;
      owner_vld_q <= '0;
      idx_q       <= '0;
    end else begin
      if (|arb_gnt) idx_q <= arb_idx;
      if (state == ISSUE && push_q && pq_push_rdy_i) begin
        owner_q[pq_push_id_i]     <= idx_q;
        owner_vld_q[pq_push_id_i] <= 1'b1;
      end else if (state == ISSUE && drop_q && pq_drop_rdy_i) begin
        owner_vld_q[id_q] <= 1'b0;
      end
    end
  end
`else
  assign owner_err = 1'b0;
`endif

  assign pre_err = ((win_op == PUSH) && pq_full_i) || ((win_op == POP) && pq_empty_i) ||
                   (win_op == RSVD) || owner_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= ARB;
      gnt_q      <= '0;
      data_q     <= '0;
      id_q       <= '0;
      push_q     <= 1'b0;
      pop_q      <= 1'b0;
      drop_q     <= 1'b0;
      rsp_vld_q  <= '0;
      rsp_err_q  <= 1'b0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
    end else begin
      rsp_vld_q <= '0;
      case (state)
        ARB: begin
          if (|arb_gnt) begin
            gnt_q  <= arb_gnt;
            data_q <= req_data_i[arb_idx];
            id_q   <= req_id_i[arb_idx];
            if (pre_err) begin
              state      <= RESP;
              rsp_vld_q  <= arb_gnt;
              rsp_err_q  <= 1'b1;
              rsp_data_q <= '0;
              rsp_id_q   <= '0;
            end else begin
              state  <= ISSUE;
              push_q <= (win_op == PUSH);
              pop_q  <= (win_op == POP);
              drop_q <= (win_op == DROP);
            end
          end
        end
        ISSUE: begin
          if (accept) begin
            state      <= RESP;
            push_q     <= 1'b0;
            pop_q      <= 1'b0;
            drop_q     <= 1'b0;
            rsp_vld_q  <= gnt_q;
            rsp_err_q  <= 1'b0;
            rsp_data_q <= pop_q ? pq_data_i : '0;
            rsp_id_q   <= push_q ? pq_push_id_i : '0;
          end
        end
        RESP:    state <= ARB;
        default: state <= ARB;
      endcase
    end
  end

  assign gnt_o        = arb_gnt;
  assign rsp_vld_o    = rsp_vld_q;
  assign rsp_err_o    = rsp_err_q;
  assign rsp_data_o   = rsp_data_q;
  assign rsp_id_o     = rsp_id_q;
  assign pq_push_o    = push_q;
  assign pq_pop_o     = pop_q;
  assign pq_drop_o    = drop_q;
  assign pq_drop_id_o = id_q;
  assign pq_data_o    = data_q;

endmodule

// File: tb/tb_pq_req_arbiter.sv
// Directed bench for pq_req_arbiter: the bench plays the pq side and the requesters.
// Inputs change 2ns after a rising edge; outputs are sampled 1ns later.
module tb_pq_req_arbiter;
  import pq_pkg::*;

  localparam int N   = 4;
  localparam int DW  = DATA_WIDTH;
  localparam int IDW = $clog2(QUEUE_DEPTH) + 1;

  logic                   clk;
  logic                   rst_n;
  logic [N-1:0]           req;
  logic [N-1:0][1:0]      op;
  logic [N-1:0][DW-1:0]   rdata;
  logic [N-1:0][IDW-1:0]  rid;
  logic [N-1:0]           gnt;
  logic [N-1:0]           rsp_vld;
  logic                   rsp_err;
  logic [DW-1:0]          rsp_data;
  logic [IDW-1:0]         rsp_id;
  logic                   push_o, pop_o, drop_o;
  logic [IDW-1:0]         drop_id;
  logic [DW-1:0]          pq_wdata;
  logic [IDW-1:0]         push_id;
  logic                   push_rdy, pop_rdy, drop_rdy;
  logic                   full, empty;
  logic [DW-1:0]          pq_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  pq_req_arbiter dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .req_i         (req),
    .op_i          (op),
    .req_data_i    (rdata),
    .req_id_i      (rid),
    .gnt_o         (gnt),
    .rsp_vld_o     (rsp_vld),
    .rsp_err_o     (rsp_err),
    .rsp_data_o    (rsp_data),
    .rsp_id_o      (rsp_id),
    .pq_push_o     (push_o),
    .pq_pop_o      (pop_o),
    .pq_drop_o     (drop_o),
    .pq_drop_id_o  (drop_id),
    .pq_data_o     (pq_wdata),
    .pq_push_id_i  (push_id),
    .pq_push_rdy_i (push_rdy),
    .pq_pop_rdy_i  (pop_rdy),
    .pq_drop_rdy_i (drop_rdy),
    .pq_full_i     (full),
    .pq_empty_i    (empty),
    .pq_data_i     (pq_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [3:0] w_exp;
    rst_n = 1'b0; req = '0; op = '0; rdata = '0; rid = '0; push_id = '0;
    push_rdy = 1'b1; pop_rdy = 1'b1; drop_rdy = 1'b1;
    full = 1'b0; empty = 1'b1; pq_rdata = '0;
    step(); step();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_rsp_vld", 32'(rsp_vld), 32'h0);
    chk("rst_strobes", 32'({push_o, pop_o, drop_o}), 32'h0);
    chk("rst_rsp_fields", 32'({rsp_err, rsp_data, rsp_id}), 32'h0);
    rst_n = 1'b1;
    step();

    // Push from requester 2: grant at T, strobe at T+1, response at T+2.
    req[2] = 1'b1; op[2] = 2'(PUSH); rdata[2] = 16'h0055; push_id = 4'h3; #1;
    chk("push_gnt", 32'(gnt), 32'h4);
    chk("push_no_strobe_at_T", 32'(push_o), 32'h0);
    step(); req[2] = 1'b0; #1;
    chk("push_strobe", 32'(push_o), 32'h1);
    chk("push_pq_data", 32'(pq_wdata), 32'h55);
    chk("push_no_early_rsp", 32'(rsp_vld), 32'h0);
    step(); #1;
    chk("push_rsp_vld", 32'(rsp_vld), 32'h4);
    chk("push_rsp_id", 32'(rsp_id), 32'h3);
    chk("push_rsp_err", 32'(rsp_err), 32'h0);
    chk("push_strobe_off", 32'(push_o), 32'h0);
    step(); #1;
    chk("push_rsp_pulse", 32'(rsp_vld), 32'h0);
    chk("push_rsp_id_hold", 32'(rsp_id), 32'h3);

    // Pop from requester 1 while the queue is empty: error response at T+1.
    req[1] = 1'b1; op[1] = 2'(POP); #1;
    chk("pop_empty_gnt", 32'(gnt), 32'h2);
    step(); req[1] = 1'b0; #1;
    chk("pop_empty_rsp_vld", 32'(rsp_vld), 32'h2);
    chk("pop_empty_err", 32'(rsp_err), 32'h1);
    chk("pop_empty_no_strobe", 32'(pop_o), 32'h0);
    chk("pop_empty_rsp_id", 32'(rsp_id), 32'h0);
    step(); #1;
    chk("pop_empty_no_strobe2", 32'(pop_o), 32'h0);

    // Push rdy held low for 5 ISSUE cycles, while another request arrives and is then withdrawn.
    push_rdy = 1'b0; req[3] = 1'b1; op[3] = 2'(PUSH); rdata[3] = 16'h00AA; #1;
    chk("stall_gnt", 32'(gnt), 32'h8);
    for (int c = 0; c < 5; c++) begin
      step(); req[3] = 1'b0; req[0] = 1'b1; op[0] = 2'(PUSH); #1;
      chk("stall_push_hold", 32'(push_o), 32'h1);
      chk("stall_no_gnt", 32'(gnt), 32'h0);
      chk("stall_no_rsp", 32'(rsp_vld), 32'h0);
    end
    step(); push_rdy = 1'b1; push_id = 4'h7; req[0] = 1'b0; #1;
    chk("stall_accept_strobe", 32'(push_o), 32'h1);
    step(); #1;
    chk("stall_rsp_vld", 32'(rsp_vld), 32'h8);
    chk("stall_rsp_id", 32'(rsp_id), 32'h7);
    chk("stall_push_off", 32'(push_o), 32'h0);
    step(); #1;
    chk("withdrawn_no_gnt", 32'(gnt), 32'h0);

    // Reset asserted mid-ISSUE, with another request pending.
    push_rdy = 1'b0; req[1] = 1'b1; op[1] = 2'(PUSH); #1;
    chk("rst_mid_gnt", 32'(gnt), 32'h2);
    step(); req[1] = 1'b0; req[2] = 1'b1; op[2] = 2'(PUSH); #1;
    chk("rst_mid_strobe", 32'(push_o), 32'h1);
    rst_n = 1'b0; #1;
    chk("rst_mid_strobes_off", 32'({push_o, pop_o, drop_o}), 32'h0);
    chk("rst_mid_gnt_off", 32'(gnt), 32'h0);
    chk("rst_mid_rsp_off", 32'(rsp_vld), 32'h0);
    step(); rst_n = 1'b1; push_rdy = 1'b1;

    // All four requesters pushing: grants rotate 0,1,2,3,0.
    req = 4'b1111;
    for (int r = 0; r < N; r++) op[r] = 2'(PUSH);
    for (int n = 0; n < 5; n++) begin
      w_exp = 4'(1 << (n % 4));
      #1;
      chk("rot_gnt", 32'(gnt), 32'(w_exp));
      step(); req = req & ~w_exp; push_id = IDW'(n + 9); #1;
      chk("rot_push", 32'(push_o), 32'h1);
      chk("rot_other_strobes", 32'({pop_o, drop_o}), 32'h0);
      chk("rot_no_gnt_issue", 32'(gnt), 32'h0);
      step(); #1;
      chk("rot_rsp_vld", 32'(rsp_vld), 32'(w_exp));
      chk("rot_rsp_id", 32'(rsp_id), 32'(n + 9));
      req = req | w_exp; #1;
      chk("rot_no_gnt_in_resp", 32'(gnt), 32'h0);
      step();
    end
    req = '0;

    // Successful pop returns the pq data (pointer is at 1, so requester 2 wins).
    empty = 1'b0; pq_rdata = 16'hBEEF; req[2] = 1'b1; op[2] = 2'(POP); #1;
    chk("pop_gnt", 32'(gnt), 32'h4);
    step(); req[2] = 1'b0; #1;
    chk("pop_strobe", 32'({push_o, pop_o, drop_o}), 32'h2);
    step(); #1;
    chk("pop_rsp_vld", 32'(rsp_vld), 32'h4);
    chk("pop_rsp_data", 32'(rsp_data), 32'hBEEF);
    chk("pop_rsp_id_zero", 32'(rsp_id), 32'h0);
    chk("pop_rsp_err", 32'(rsp_err), 32'h0);
    step();

`ifdef PQ_ARB_OWNER_CHECK_EN
    // Requester 0 owns ID 5. A drop from requester 3 is refused; a drop from requester 0 goes through.
    req[0] = 1'b1; op[0] = 2'(PUSH); push_id = 4'h5; #1;
    chk("own_push_gnt", 32'(gnt), 32'h1);
    step(); req[0] = 1'b0;
    step(); #1;
    chk("own_push_rsp_id", 32'(rsp_id), 32'h5);
    step();
    req[3] = 1'b1; op[3] = 2'(DROP); rid[3] = 4'h5; #1;
    chk("own_bad_gnt", 32'(gnt), 32'h8);
    step(); req[3] = 1'b0; #1;
    chk("own_bad_rsp_vld", 32'(rsp_vld), 32'h8);
    chk("own_bad_err", 32'(rsp_err), 32'h1);
    chk("own_bad_no_drop", 32'(drop_o), 32'h0);
    step();
    req[0] = 1'b1; op[0] = 2'(DROP); rid[0] = 4'h5; #1;
    chk("own_ok_gnt", 32'(gnt), 32'h1);
    step(); req[0] = 1'b0; #1;
    chk("own_ok_drop", 32'(drop_o), 32'h1);
    chk("own_ok_drop_id", 32'(drop_id), 32'h5);
    step(); #1;
    chk("own_ok_rsp_vld", 32'(rsp_vld), 32'h1);
    chk("own_ok_err", 32'(rsp_err), 32'h0);
`else
    // A drop is always forwarded, even for an ID that was never pushed.
    req[3] = 1'b1; op[3] = 2'(DROP); rid[3] = 4'h9; #1;
    chk("drop_gnt", 32'(gnt), 32'h8);
    step(); req[3] = 1'b0; #1;
    chk("drop_strobe", 32'({push_o, pop_o, drop_o}), 32'h1);
    chk("drop_id", 32'(drop_id), 32'h9);
    step(); #1;
    chk("drop_rsp_vld", 32'(rsp_vld), 32'h8);
    chk("drop_rsp_err", 32'(rsp_err), 32'h0);
    chk("drop_rsp_fields", 32'({rsp_data, rsp_id}), 32'h0);
`endif
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pq_req_arbiter.md
Name: pq_req_arbiter

Overview:
- Shares one `pq` priority-queue instance between NUM_REQ independent requesters.
- Uses round-robin arbitration and issues one PUSH, POP or DROP per transaction to the queue.
- Returns the push ID, popped data or an error to the granted requester.
- Sits between client logic and `pq`; it is the only block that drives the `pq` control inputs.

Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- DEPTH, QUEUE_DEPTH, queue depth forwarded from the package.
- DW, DATA_WIDTH, data width.
- ID_WIDTH, $clog2(DEPTH)+1, push/drop ID width (localparam).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  NUM_REQ  per-requester request valid
- op_i  in  NUM_REQ x 2  per-requester op: 0=PUSH, 1=POP, 2=DROP, 3=reserved
- req_data_i  in  NUM_REQ x DW  push data
- req_id_i  in  NUM_REQ x ID_WIDTH  drop ID
- gnt_o  out  NUM_REQ  one-hot grant pulse
- rsp_vld_o  out  NUM_REQ  one-hot response pulse
- rsp_err_o  out  1  response error flag
- rsp_data_o  out  DW  popped data
- rsp_id_o  out  ID_WIDTH  assigned push ID
- pq_push_o, pq_pop_o, pq_drop_o  out  1 each  strobes to `pq`
- pq_drop_id_o  out  ID_WIDTH  drop ID to `pq`
- pq_data_o  out  DW  push data to `pq`
- pq_push_id_i  in  ID_WIDTH  from `pq`
- pq_push_rdy_i, pq_pop_rdy_i, pq_drop_rdy_i  in  1 each  from `pq`
- pq_full_i, pq_empty_i  in  1 each  from `pq`
- pq_data_i  in  DW  pop data from `pq`

Behaviour:
- Reset: all outputs 0, state ARB, round-robin pointer 0.
- Requester handshake:
  - Requester holds req_i and its fields stable until gnt_o. Grant is a 1-cycle pulse.
  - Requester keeps req_i low until its rsp_vld_o.
  - Dropping req_i before grant is legal; the request is withdrawn.
- `pq` contract:
  - An op is accepted in the cycle where its strobe and matching rdy are both high.
  - pq_push_id_i and pq_data_i are valid in that same cycle.
- State ARB:
  - Pick the first asserted req_i at or after the pointer (wrapping); assert gnt_o for it.
  - Latch op, data, ID and grant index. Pointer becomes winner+1 mod NUM_REQ.
  - No req_i asserted: stay in ARB.
- Precheck in the grant cycle:
  - PUSH with pq_full_i=1, POP with pq_empty_i=1, or op=3: go to RESP with err=1. Nothing is sent to `pq`.
  - Otherwise go to ISSUE.
- State ISSUE:
  - Drive the selected strobe and hold it until the matching rdy is seen.
  - On acceptance, capture pq_push_id_i (PUSH) or pq_data_i (POP), then go to RESP.
  - Strobes are never asserted outside ISSUE; at most one strobe is high.
- State RESP:
  - rsp_vld_o[idx]=1 for one cycle with rsp_err_o, rsp_data_o and rsp_id_o; return to ARB.
  - rsp_data_o=0 unless POP; rsp_id_o=0 unless PUSH.
  - rsp_* fields hold until the next RESP.
- Latency:
  - Grant at cycle T.
  - Earliest acceptance at T+1, response at T+2.
  - Error response at T+1.
- Throughput: one op per 3 cycles, or 2 cycles for an error.
- Boundary cases:
  - A request arriving in the same cycle as RESP waits for ARB.
  - With all requesters asserting, grants rotate 0,1,2,3,0.
  - Reset mid-ISSUE drops strobes immediately; the in-flight op result is lost.
  - DROP of an invalid ID is forwarded; `pq` handles it, and the response reports err=0.

Optional Feature:
- PQ_ARB_OWNER_CHECK_EN:
  - Adds an owner table of 2^ID_WIDTH entries, each $clog2(NUM_REQ) bits plus a valid bit.
  - A PUSH response sets owner[id] to the requester and marks the entry valid.
  - A POP clears the entry whose ID matches the popped element only if `pq` exposes the popped ID; otherwise entries clear on DROP only.
  - DROP is checked in the grant cycle: if the entry is invalid or owned by another requester, go to RESP with err=1 and no `pq` op.
- Without the macro: no table, and every DROP is forwarded.

Decomposition:
- pq_pkg gains:
  - pq_op_e (PUSH/POP/DROP/RSVD, 2 bits)
  - pq_arb_state_e (ARB/ISSUE/RESP)
  - PQ_ARB_NUM_REQ default constant
- Sub-module `rr_arbiter` (NUM_REQ): req vector, pointer update enable, one-hot grant and index out; purely combinational priority rotation plus registered pointer.

Test Plan:
- Reset, then req_i[2]=1 PUSH data 0x55 with `pq` empty → gnt_o=4'b0100 at T; pq_push_o at T+1; rsp_vld_o[2] at T+2 with rsp_id_o equal to the `pq` ID, err=0.
- POP from requester 1 with pq_empty_i=1 → rsp_vld_o[1] at T+1, err=1, pq_pop_o never asserted.
- req_i=4'b1111, all PUSH → grants in order 0,1,2,3,0; each response goes to the matching requester; no overlap of strobes.
- pq_push_rdy_i held low 5 cycles during ISSUE → pq_push_o held 5 cycles; response 1 cycle after rdy rises; no new grant meanwhile.
- rst_ni asserted during ISSUE → all strobes, gnt_o and rsp_vld_o are 0 the same cycle; after release the first grant goes to requester 0.
- PQ_ARB_OWNER_CHECK_EN: requester 0 pushes (ID k), then requester 3 drops k → err=1, no pq_drop_o; requester 0 drops k → pq_drop_o with ID k, err=0.
